lcd_spi_arbiter: RTL and testbench
==================================

LCD_SPI_ARBITER -- requirements
Module: lcd_spi_arbiter

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of clk cycles lcd_rst is held low after reset release.
REQ-002 Parameter TIMEOUT, default 1024: maximum number of clk cycles one transfer may take from grant to spi_avail.
REQ-003 Port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-low.
REQ-005 Ports req0/req1, input, 1 each: requester 0 (init/command sequencer) and requester 1 (frame writer) each request one byte transfer.
REQ-006 Ports byte0/byte1, input, 8 each: byte to send for the matching requester.
REQ-007 Ports dc0/dc1, input, 1 each: data/command flag for that byte; 1 = data, 0 = command.
REQ-008 Ports gnt0/gnt1, output, 1 each: the requester owns the SPI master.
REQ-009 Ports done0/done1, output, 1 each: one-cycle pulse when the requester's transfer ends.
REQ-010 Port err, output, 1: one-cycle pulse when a transfer is aborted by timeout.
REQ-011 Port spi_data, output, 8: connects to data_in of spi_master.
REQ-012 Port spi_start, output, 1: connects to start of spi_master.
REQ-013 Ports spi_busy/spi_avail, input, 1 each: connect to busy and avail of spi_master.
REQ-014 Port dc, output, 1: LCD D/C pin.
REQ-015 Port lcd_rst, output, 1: LCD reset pin, active-low.

Function
REQ-016 The controller SHALL use the states RST_LCD, IDLE, START, XFER and RELEASE.
REQ-017 RST_LCD: lcd_rst=0 and no grants are issued; after RST_CYCLES cycles the controller SHALL set lcd_rst=1 and go to IDLE.
REQ-018 lcd_rst SHALL stay 1 until the next reset.
REQ-019 IDLE, arbitration: with any req high at an edge, that same edge SHALL assert exactly one gnt, latch the winner's byte into spi_data and its dc flag into dc, and go to START.
REQ-020 Arbitration SHALL be round-robin. A one-bit pointer marks the last requester served; when both requests are high, the other requester wins.
REQ-021 The round-robin pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-022 START: spi_start=1 SHALL be held until spi_busy is sampled high, then the controller goes to XFER.
REQ-023 XFER: when spi_avail is sampled high, the controller SHALL drive spi_start=0, pulse done for the granted requester for 1 cycle, and go to RELEASE.
REQ-024 RELEASE: gnt SHALL be deasserted and the pointer updated.
REQ-025 From RELEASE the controller SHALL return to IDLE only once spi_avail and spi_busy are both low, so one transfer is never counted twice.
REQ-026 spi_data and dc SHALL remain stable from grant until RELEASE exits; dc SHALL hold its last value while idle.
REQ-027 A requester keeps req, byte and dc stable until its done; it may drop req in the done cycle or keep it high for back-to-back bytes.
REQ-028 Back-to-back bytes from one requester SHALL alternate with the other requester whenever both are requesting.
REQ-029 A req that falls before grant SHALL be ignored; no partial transfer occurs.
REQ-030 Timeout: a cycle counter SHALL count from grant, saturating at TIMEOUT.
REQ-031 When the counter reaches TIMEOUT while in START or XFER, the controller SHALL drop spi_start, pulse err and the granted done together for 1 cycle, and go to RELEASE.
REQ-032 At most one gnt SHALL be high at any time, and no gnt SHALL be high in RST_LCD.
REQ-033 When spi_avail and the timeout occur in the same cycle, the transfer SHALL count as successful: done without err.

Reset
REQ-034 While reset=0, the controller SHALL hold state=RST_LCD, lcd_rst=0, gnt0=gnt1=0, done0=done1=0, err=0, spi_start=0, spi_data=8'h00, dc=0, pointer=1 and all counters at 0.
REQ-035 Reset asserted mid-transfer SHALL abort immediately, with no done or err pulse.
REQ-036 After reset release the controller SHALL repeat the full RST_CYCLES LCD reset sequence.

Verification
REQ-037 Scenario, LCD reset: release reset with req0 already high -> lcd_rst low for exactly 16 cycles, then gnt0 on the first IDLE edge.
REQ-038 Scenario, single command: req0=1, byte0=8'h21, dc0=0 -> spi_data=8'h21, dc=0, spi_start high until spi_busy, one done0 pulse after spi_avail.
REQ-039 Scenario, contention: req0 and req1 held high continuously with bytes 8'h0C and 8'hFF -> grants alternate 0,1,0,1; dc follows dc0/dc1; done pulses match the grants.
REQ-040 Scenario, timeout: spi_busy never asserts with TIMEOUT=8 -> err and done0 pulse together 8 cycles after grant; spi_start=0; the next request is served normally.
REQ-041 Scenario, mid-transfer reset: assert reset while in XFER -> all outputs at reset values asynchronously, no done pulse, then the lcd_rst sequence repeats.
REQ-042 Scenario, simultaneous avail and timeout: spi_avail rises in the same cycle the timeout is reached -> done pulses with err=0.

Source files
------------

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter that shares one SPI master between the LCD init/command
// sequencer (requester 0) and the frame writer (requester 1), and drives the LCD reset pin.
module lcd_spi_arbiter #(
    parameter int RST_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic       dc0,
    input  logic       dc1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] spi_data,
    output logic       spi_start,
    input  logic       spi_busy,
    input  logic       spi_avail,
    output logic       dc,
    output logic       lcd_rst
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        RST_LCD,
        IDLE,
        START,
        XFER,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            ptr_q, ptr_d;

    logic            lcd_rst_d, gnt0_d, gnt1_d, done0_d, done1_d, err_d;
    logic            spi_start_d, dc_d;
    logic [7:0]      spi_data_d;

    logic            pick1;
    logic            to_hit;
    logic            end_xfer;
    logic            end_err;
    logic [TW-1:0]   to_cnt_inc;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        to_cnt_d    = to_cnt_q;
        ptr_d       = ptr_q;
        lcd_rst_d   = lcd_rst;
        gnt0_d      = gnt0;
        gnt1_d      = gnt1;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        spi_start_d = spi_start;
        spi_data_d  = spi_data;
        dc_d        = dc;
        end_xfer    = 1'b0;
        end_err     = 1'b0;

        // ptr_q remembers the last requester served; on a tie the other one wins
        pick1      = req1 & (~req0 | ~ptr_q);
        // the counter becomes TIMEOUT on this edge
        to_hit     = (to_cnt_q >= TW'(TIMEOUT - 1));
        to_cnt_inc = (to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TW'(1);

        case (state_q)
            RST_LCD: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    lcd_rst_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            IDLE: begin
                if (req0 | req1) begin
                    gnt0_d      = ~pick1;
                    gnt1_d      = pick1;
                    spi_data_d  = pick1 ? byte1 : byte0;
                    dc_d        = pick1 ? dc1 : dc0;
                    spi_start_d = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = START;
                end
            end
            START: begin
                to_cnt_d = to_cnt_inc;
                if (to_hit) begin
                    end_xfer = 1'b1;
                    end_err  = 1'b1;
                end else if (spi_busy) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                to_cnt_d = to_cnt_inc;
                // a completion seen on the timeout edge still counts as success
                if (spi_avail) begin
                    end_xfer = 1'b1;
                end else if (to_hit) begin
                    end_xfer = 1'b1;
                    end_err  = 1'b1;
                end
            end
            RELEASE: begin
                // wait for the master to settle so the same completion is not seen twice
                if (!spi_avail && !spi_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RST_LCD;
            end
        endcase

        if (end_xfer) begin
            spi_start_d = 1'b0;
            done0_d     = gnt0;
            done1_d     = gnt1;
            err_d       = end_err;
            gnt0_d      = 1'b0;
            gnt1_d      = 1'b0;
            ptr_d       = gnt1;
            state_d     = RELEASE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RST_LCD;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            ptr_q     <= 1'b1;
            lcd_rst   <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= 8'h00;
            dc        <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ptr_q     <= ptr_d;
            lcd_rst   <= lcd_rst_d;
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            err       <= err_d;
            spi_start <= spi_start_d;
            spi_data  <= spi_data_d;
            dc        <= dc_d;
        end
    end

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Scoreboard bench for lcd_spi_arbiter: a transaction-level model predicts the service
// order and outcome of every byte, a monitor checks each done pulse against it.
`timescale 1ns/1ps
module tb_lcd_spi_arbiter;

    localparam int RSTC = 16;
    localparam int TO   = 8;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [7:0] byte0, byte1;
    logic       dc0, dc1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] spi_data;
    logic       spi_start;
    logic       spi_busy, spi_avail;
    logic       dc, lcd_rst;

    lcd_spi_arbiter #(.RST_CYCLES(RSTC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .byte0(byte0), .byte1(byte1), .dc0(dc0), .dc1(dc1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .spi_data(spi_data), .spi_start(spi_start), .spi_busy(spi_busy), .spi_avail(spi_avail),
        .dc(dc), .lcd_rst(lcd_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; logic [7:0] data; logic dcf; logic errf; } exp_t;
    typedef struct { int busy_at; int avail_at; } beh_t;

    exp_t       exp_q[$];
    beh_t       beh_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         model_ptr = 1;
    logic [7:0] b_arr [2][4];
    logic       d_arr [2][4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One SPI transfer as seen by the model: who is served, what is sent, how the master behaves.
    task automatic push_xfer(input int id, input logic [7:0] data, input logic dcf,
                             input int busy_at, input int avail_at, input logic errf,
                             input bit expect_done);
        exp_t e;
        beh_t b;
        e.id = id; e.data = data; e.dcf = dcf; e.errf = errf;
        b.busy_at = busy_at; b.avail_at = avail_at;
        beh_q.push_back(b);
        if (expect_done) begin
            exp_q.push_back(e);
            model_ptr = id;
        end
    endtask

    // Round-robin order: while both have bytes left they alternate, starting with the
    // requester not served last; then the remaining one drains.
    task automatic plan_round(input int n0, input int n1, input bit faults);
        int c0 = 0;
        int c1 = 0;
        int w, idx, kind, ba;
        while (c0 < n0 || c1 < n1) begin
            if (c0 < n0 && c1 < n1) w = (model_ptr == 1) ? 0 : 1;
            else                    w = (c0 < n0) ? 0 : 1;
            idx  = (w == 1) ? c1 : c0;
            kind = faults ? int'($urandom_range(0, 9)) : 0;
            if (kind < 6) begin
                ba = int'($urandom_range(0, 2));
                push_xfer(w, b_arr[w][idx], d_arr[w][idx], ba, ba + int'($urandom_range(1, 3)), 1'b0, 1'b1);
            end else if (kind == 6) begin
                push_xfer(w, b_arr[w][idx], d_arr[w][idx], -1, -1, 1'b1, 1'b1);
            end else if (kind == 7) begin
                push_xfer(w, b_arr[w][idx], d_arr[w][idx], int'($urandom_range(0, 3)), -1, 1'b1, 1'b1);
            end else begin
                push_xfer(w, b_arr[w][idx], d_arr[w][idx], int'($urandom_range(0, 5)), TO - 1, 1'b0, 1'b1);
            end
            if (w == 1) c1++; else c0++;
        end
    endtask

    task automatic drive(input int id, input logic r, input logic [7:0] b, input logic d);
        if (id == 0) begin req0 = r; byte0 = b; dc0 = d; end
        else         begin req1 = r; byte1 = b; dc1 = d; end
    endtask

    task automatic wait_done(input int id);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!((id == 0) ? done0 : done1) && t < 200);
        checks++;
        if (!((id == 0) ? done0 : done1)) begin
            errors++;
            $display("FAIL done_wait: requester %0d saw no done within %0d cycles", id, t);
        end
    endtask

    task automatic wait_gnt(input int id);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!((id == 0) ? gnt0 : gnt1) && t < 50);
        checks++;
        if (!((id == 0) ? gnt0 : gnt1)) begin
            errors++;
            $display("FAIL gnt_wait: requester %0d saw no grant within %0d cycles", id, t);
        end
    endtask

    task automatic requester(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            drive(id, 1'b1, b_arr[id][i], d_arr[id][i]);
            wait_done(id);
        end
        drive(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lcd_rst"}, 32'(lcd_rst), 0);
        chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 0);
        chk({tag, "_done"}, 32'({done0, done1}), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_spi_start"}, 32'(spi_start), 0);
        chk({tag, "_spi_data"}, 32'(spi_data), 0);
        chk({tag, "_dc"}, 32'(dc), 0);
    endtask

    task automatic lcd_reset_seq();
        for (int k = 1; k <= RSTC; k++) begin
            @(negedge clk);
            chk("lcd_rst_seq", 32'(lcd_rst), 32'(k == RSTC));
            chk("no_gnt_in_lcd_rst", 32'(gnt0 | gnt1), 0);
        end
    endtask

    // SPI master stand-in: after spi_start is seen, raise busy and then avail on the
    // negedges given by the next behaviour entry (-1 = never).
    initial begin : spi_model
        int   k;
        bit   active;
        beh_t b;
        spi_busy = 1'b0; spi_avail = 1'b0; active = 0; k = 0;
        b.busy_at = 0; b.avail_at = 2;
        forever begin
            @(negedge clk);
            if (spi_start !== 1'b1) begin
                spi_busy = 1'b0; spi_avail = 1'b0; active = 0;
            end else begin
                if (!active) begin
                    active = 1; k = 0;
                    if (beh_q.size() > 0) b = beh_q.pop_front();
                    else begin b.busy_at = 0; b.avail_at = 2; end
                end else begin
                    k++;
                end
                if (k == b.busy_at) spi_busy = 1'b1;
                if (k == b.avail_at) begin spi_avail = 1'b1; spi_busy = 1'b0; end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
            chk("gnt_in_lcd_rst", 32'(~lcd_rst & (gnt0 | gnt1)), 0);
            chk("err_without_done", 32'(err & ~(done0 | done1)), 0);
            if (done0 || done1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: done0=%0b done1=%0b with no transfer expected", done0, done1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_single_done", 32'(done0 & done1), 0);
                    chk("sb_id", 32'(done1), mon_e.id);
                    chk("sb_data", 32'(spi_data), 32'(mon_e.data));
                    chk("sb_dc", 32'(dc), 32'(mon_e.dcf));
                    chk("sb_err", 32'(err), 32'(mon_e.errf));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n0, n1;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; byte0 = 8'h00; byte1 = 8'h00; dc0 = 1'b0; dc1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // LCD reset with req0 already pending, then a single command byte
        drive(0, 1'b1, 8'h21, 1'b0);
        push_xfer(0, 8'h21, 1'b0, 2, 4, 1'b0, 1'b1);
        reset = 1'b1;
        lcd_reset_seq();
        @(negedge clk);
        chk("first_gnt0", 32'(gnt0), 1);
        chk("first_data", 32'(spi_data), 32'h21);
        chk("first_dc", 32'(dc), 0);
        chk("first_start", 32'(spi_start), 1);
        repeat (2) @(negedge clk);
        chk("start_held", 32'(spi_start), 1);
        wait_done(0);
        chk("start_dropped", 32'(spi_start), 0);
        drive(0, 1'b0, 8'h00, 1'b0);

        // master never goes busy: err and done0 together TO cycles after grant
        @(negedge clk);
        drive(0, 1'b1, 8'hA5, 1'b1);
        push_xfer(0, 8'hA5, 1'b1, -1, -1, 1'b1, 1'b1);
        wait_gnt(0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k < TO) chk("timeout_early_err", 32'(err), 0);
        end
        chk("timeout_err", 32'(err), 1);
        chk("timeout_done0", 32'(done0), 1);
        chk("timeout_start", 32'(spi_start), 0);
        drive(0, 1'b0, 8'h00, 1'b0);

        // completion on the timeout edge counts as success
        @(negedge clk);
        drive(0, 1'b1, 8'h5A, 1'b0);
        push_xfer(0, 8'h5A, 1'b0, 1, TO - 1, 1'b0, 1'b1);
        wait_gnt(0);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k < TO) chk("tie_early_done", 32'(done0), 0);
        end
        chk("tie_done0", 32'(done0), 1);
        chk("tie_err", 32'(err), 0);
        drive(0, 1'b0, 8'h00, 1'b0);

        // reset in the middle of a transfer: abort silently, LCD reset repeats
        @(negedge clk);
        drive(0, 1'b1, 8'h3C, 1'b1);
        push_xfer(0, 8'h3C, 1'b1, 0, -1, 1'b0, 1'b0);
        wait_gnt(0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        drive(0, 1'b0, 8'h00, 1'b0);
        model_ptr = 1;
        @(negedge clk);
        reset = 1'b1;
        lcd_reset_seq();

        // continuous contention: grants alternate 0,1,0,1
        for (int i = 0; i < 2; i++) begin
            b_arr[0][i] = 8'h0C; d_arr[0][i] = 1'b0;
            b_arr[1][i] = 8'hFF; d_arr[1][i] = 1'b1;
        end
        plan_round(2, 2, 1'b0);
        fork
            requester(0, 2);
            requester(1, 2);
        join

        // randomized rounds with random master behaviour
        for (int r = 0; r < 25; r++) begin
            n0 = int'($urandom_range(0, 3));
            n1 = int'($urandom_range(0, 3));
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int i = 0; i < 4; i++) begin
                b_arr[0][i] = 8'($urandom); d_arr[0][i] = 1'($urandom);
                b_arr[1][i] = 8'($urandom); d_arr[1][i] = 1'($urandom);
            end
            plan_round(n0, n1, 1'b1);
            fork
                requester(0, n0);
                requester(1, n1);
            join
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
